// File: rtl/store_checker_pkg.sv
// Shared types and default constants for the store checker.
// Imported by the table and the top-level checker.
package store_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_IGNORE_ADDR = 80;
  localparam int DEF_TIMEOUT     = 1000;

endpackage

// File: rtl/store_checker_table.sv
// Expected-store register file: one write port, one async read port.
// Each entry packs {address, data}.
module store_checker_table
  import store_checker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IW    = $clog2(DEF_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    ridx,
  output logic [WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = {waddr, wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign {raddr, rdata} = mem_q[ridx];

endmodule

// File: rtl/store_checker.sv
// Compares processor stores against an ordered table of expected
// stores and reports pass, fail or timeout.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int IGNORE_ADDR    = DEF_IGNORE_ADDR,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic [WIDTH-1:0]           load_addr,
  input  logic [WIDTH-1:0]           load_data,
  input  logic [$clog2(DEPTH+1)-1:0] exp_count,
  input  logic                       start,
  input  logic                       memwrite,
  input  logic [WIDTH-1:0]           dataadr,
  input  logic [WIDTH-1:0]           writedata,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] match_count,
  output logic [WIDTH-1:0]           fail_addr,
  output logic [WIDTH-1:0]           fail_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0]    TMO_LST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH-1:0] IGN     = WIDTH'(IGNORE_ADDR);

  state_e           state_q, state_d;
  logic [CW-1:0]    mc_q, mc_d;
  logic [CW-1:0]    exp_q, exp_d;
  logic [TW-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fd_q, fd_d;
  logic             pass_q, fail_q, tmo_q, done_q;

  logic [WIDTH-1:0] exp_addr, exp_data;
  logic             rd_ok, hit, ign, last;
  logic             tbl_we;

  assign tbl_we = load_en && (state_q != S_RUN);

  store_checker_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .widx  (load_idx),
    .waddr (load_addr),
    .wdata (load_data),
    .ridx  (mc_q[IW-1:0]),
    .raddr (exp_addr),
    .rdata (exp_data)
  );

  // Only the entry at the current match position may match.
  assign rd_ok = (mc_q < exp_q) && (mc_q < DEPTH_C);
  assign hit   = memwrite && rd_ok &&
                 (dataadr == exp_addr) &&
                 (writedata == exp_data);
  assign ign   = (dataadr == IGN);
  assign last  = (cyc_q == TMO_LST);

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    exp_d   = exp_q;
    cyc_d   = cyc_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    unique case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + TW'(1);
        if (exp_q == '0) begin
          state_d = S_PASS;
        end else if (hit) begin
          mc_d = mc_q + CW'(1);
          if (mc_d == exp_q) begin
            state_d = S_PASS;
          end else if (last) begin
            state_d = S_TIMEOUT;
          end
        end else if (memwrite && !ign) begin
          state_d = S_FAIL;
          fa_d    = dataadr;
          fd_d    = writedata;
        end else if (last) begin
          state_d = S_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          exp_d   = exp_count;
          mc_d    = '0;
          cyc_d   = '0;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      exp_q   <= '0;
      cyc_q   <= '0;
      fa_q    <= '0;
      fd_q    <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      exp_q   <= exp_d;
      cyc_q   <= cyc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
      pass_q  <= (state_d == S_PASS);
      fail_q  <= (state_d == S_FAIL);
      tmo_q   <= (state_d == S_TIMEOUT);
      done_q  <= (state_d == S_PASS) ||
                 (state_d == S_FAIL) ||
                 (state_d == S_TIMEOUT);
    end
  end

  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign done        = done_q;
  assign match_count = mc_q;
  assign fail_addr   = fa_q;
  assign fail_data   = fd_q;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker with a cycle-level reference model
// compared on every negedge, plus literal spot checks.
module tb_store_checker;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [2:0]  exp_count;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        pass, fail, timeout, done;
  logic [2:0]  match_count;
  logic [31:0] fail_addr, fail_data;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  store_checker #(
    .WIDTH          (32),
    .DEPTH          (4),
    .IGNORE_ADDR    (80),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_idx    (load_idx),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .exp_count   (exp_count),
    .start       (start),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout),
    .done        (done),
    .match_count (match_count),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data)
  );

  always #5 clk = ~clk;

  // Reference model: outcome-level view of the checker.
  typedef enum int {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TMO} mst_e;
  mst_e        m_st = M_IDLE;
  logic [31:0] m_ta [4];
  logic [31:0] m_td [4];
  int          m_exp, m_mc, m_elapsed;
  logic [31:0] m_fa, m_fd;

  always @(posedge clk) begin
    if (!reset) begin
      m_st = M_IDLE;
      m_exp = 0;
      m_mc = 0;
      m_elapsed = 0;
      m_fa = 0;
      m_fd = 0;
      for (int i = 0; i < 4; i++) begin
        m_ta[i] = 0;
        m_td[i] = 0;
      end
    end else if (m_st == M_RUN) begin
      bit hit;
      hit = 0;
      m_elapsed++;
      if (memwrite && m_mc < m_exp && m_mc < 4)
        hit = (dataadr == m_ta[m_mc]) &&
              (writedata == m_td[m_mc]);
      if (m_exp == 0) begin
        m_st = M_PASS;
      end else if (hit) begin
        m_mc++;
        if (m_mc == m_exp) m_st = M_PASS;
        else if (m_elapsed == TMO) m_st = M_TMO;
      end else if (memwrite && dataadr != 80) begin
        m_st = M_FAIL;
        m_fa = dataadr;
        m_fd = writedata;
      end else if (m_elapsed == TMO) begin
        m_st = M_TMO;
      end
    end else begin
      if (load_en) begin
        m_ta[load_idx] = load_addr;
        m_td[load_idx] = load_data;
      end
      if (start) begin
        m_st = M_RUN;
        m_exp = int'(exp_count);
        m_mc = 0;
        m_elapsed = 0;
        m_fa = 0;
        m_fd = 0;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pass", 32'(pass), 32'(m_st == M_PASS));
      chk("m_fail", 32'(fail), 32'(m_st == M_FAIL));
      chk("m_tmo", 32'(timeout), 32'(m_st == M_TMO));
      chk("m_done", 32'(done),
          32'(m_st inside {M_PASS, M_FAIL, M_TMO}));
      chk("m_mc", 32'(match_count), 32'(m_mc));
      chk("m_faddr", fail_addr, m_fa);
      chk("m_fdata", fail_data, m_fd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int a, input int d);
    load_en   = 1;
    load_idx  = 2'(idx);
    load_addr = 32'(a);
    load_data = 32'(d);
    cyc();
    load_en = 0;
  endtask

  task automatic go(input int n);
    exp_count = 3'(n);
    start     = 1;
    cyc();
    start = 0;
  endtask

  task automatic store(input int a, input int d);
    memwrite  = 1;
    dataadr   = 32'(a);
    writedata = 32'(d);
    cyc();
    memwrite = 0;
  endtask

  initial begin
    reset = 0;
    load_en = 0;
    load_idx = 0;
    load_addr = 0;
    load_data = 0;
    exp_count = 0;
    start = 0;
    memwrite = 0;
    dataadr = 0;
    writedata = 0;
    cyc();
    chk_en = 1;
    cyc();
    chk("rst_done", 32'(done), 0);
    chk("rst_mc", 32'(match_count), 0);
    reset = 1;

    // Ignored scratch store, then the expected one
    load(0, 84, 7);
    go(1);
    store(80, 5);
    chk("t1_pass_early", 32'(pass), 0);
    store(84, 7);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_done", 32'(done), 1);
    chk("t1_mc", 32'(match_count), 1);
    cyc();
    chk("t1_hold", 32'(pass), 1);

    // Wrong address
    go(1);
    chk("t2_rearm", 32'(done), 0);
    store(88, 7);
    chk("t2_fail", 32'(fail), 1);
    chk("t2_faddr", fail_addr, 88);
    chk("t2_fdata", fail_data, 7);
    chk("t2_pass", 32'(pass), 0);

    // Only scratch stores -> timeout after 16 RUN cycles
    go(1);
    for (int i = 0; i < TMO - 1; i++) store(80, i);
    chk("t3_not_yet", 32'(timeout), 0);
    store(80, 99);
    chk("t3_tmo", 32'(timeout), 1);
    chk("t3_mc", 32'(match_count), 0);

    // Out-of-order store fails, in-order passes
    load(1, 88, 3);
    go(2);
    store(88, 3);
    chk("t4_fail", 32'(fail), 1);
    chk("t4_faddr", fail_addr, 88);
    go(2);
    store(84, 7);
    store(88, 3);
    chk("t4_pass", 32'(pass), 1);
    chk("t4_mc", 32'(match_count), 2);

    // Load and start during RUN are ignored
    go(1);
    load(0, 92, 1);
    go(3);
    store(84, 7);
    chk("t5_pass", 32'(pass), 1);

    // Empty expectation passes on first RUN cycle
    go(0);
    cyc();
    chk("t6_pass0", 32'(pass), 1);

    // Reset mid-RUN after one match; table cleared
    go(2);
    store(84, 7);
    chk("t7_mc1", 32'(match_count), 1);
    reset = 0;
    cyc();
    chk("t7_done", 32'(done), 0);
    chk("t7_mc", 32'(match_count), 0);
    reset = 1;
    go(1);
    store(84, 7);
    chk("t7_cleared", 32'(fail), 1);

    // Final match on the last counter value beats timeout
    load(0, 84, 7);
    load(1, 88, 3);
    go(2);
    store(84, 7);
    repeat (TMO - 2) cyc();
    store(88, 3);
    chk("t8_pass", 32'(pass), 1);
    chk("t8_tmo", 32'(timeout), 0);

    // Mismatch on the last counter value beats timeout
    go(1);
    repeat (TMO - 1) cyc();
    store(44, 2);
    chk("t9_fail", 32'(fail), 1);
    chk("t9_tmo", 32'(timeout), 0);

    cyc();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data and address bus width.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of expected-store table entries.
REQ-003 Parameter IGNORE_ADDR, default 80, SHALL name the one scratch address whose stores are ignored.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the RUN-state cycle limit.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- load_en  in  1  write one table entry
- load_idx  in  clog2(DEPTH)  table entry index
- load_addr  in  WIDTH  expected store address
- load_data  in  WIDTH  expected store data
- exp_count  in  clog2(DEPTH+1)  number of entries to check; sampled at start
- start  in  1  arm checker (pulse)
- memwrite  in  1  processor data-memory write strobe
- dataadr  in  WIDTH  processor store address
- writedata  in  WIDTH  processor store data
- pass  out  1  all expected stores seen in order
- fail  out  1  unexpected store seen
- timeout  out  1  cycle limit reached
- done  out  1  pass | fail | timeout
- match_count  out  clog2(DEPTH+1)  entries matched so far
- fail_addr  out  WIDTH  address of offending store
- fail_data  out  WIDTH  data of offending store

Function
REQ-006 FSM states SHALL be IDLE, RUN, PASS, FAIL, TIMEOUT; all outputs registered.
REQ-007 In IDLE and terminal states, load_en SHALL write load_addr/load_data into entry load_idx on the next edge; load_en in RUN SHALL be ignored.
REQ-008 start in IDLE or any terminal state SHALL enter RUN next cycle, latch exp_count, clear match_count, cycle counter, fail_addr, fail_data, and deassert pass/fail/timeout/done; start in RUN SHALL be ignored.
REQ-009 If the latched exp_count is 0, the block SHALL go RUN -> PASS on the first RUN cycle regardless of memwrite.
REQ-010 In RUN, memwrite=1 with dataadr/writedata equal to entry[match_count] SHALL increment match_count; if the new count equals exp_count, next state SHALL be PASS.
REQ-011 In RUN, memwrite=1 with dataadr==IGNORE_ADDR and no match SHALL cause no state or count change.
REQ-012 In RUN, any other memwrite=1 SHALL go to FAIL and capture dataadr/writedata into fail_addr/fail_data.
REQ-013 memwrite=0 SHALL never change match_count or cause FAIL.
REQ-014 The cycle counter SHALL increment every RUN cycle; on reaching TIMEOUT_CYCLES-1 without PASS/FAIL, next state SHALL be TIMEOUT.
REQ-015 Simultaneous final match and timeout SHALL resolve to PASS; simultaneous mismatch and timeout SHALL resolve to FAIL.
REQ-016 pass/fail/timeout SHALL be one-hot and asserted exactly in the matching state; done SHALL equal their OR.
REQ-017 Terminal states SHALL hold all outputs until start or reset.
REQ-018 Latency: flag assertion SHALL occur on the edge after the deciding memwrite cycle.

Reset
REQ-019 reset=0 at a rising edge SHALL force IDLE, all outputs 0, counters 0, from any state including mid-RUN.
REQ-020 Table contents SHALL be cleared to 0 by reset.

Structure
REQ-021 Package store_checker_pkg SHALL hold the state enum and default parameter constants.
REQ-022 The expected table SHALL be sub-module store_checker_table (DEPTH x 2*WIDTH register file, one write port, one async read port).

Verification
REQ-023 Table {0:(84,7)}, exp_count=1, start; stores (80,5),(84,7) -> pass=1, done=1 one cycle after the (84,7) store, match_count=1.
REQ-024 Same setup; store (88,7) -> fail=1, fail_addr=88, fail_data=7, pass=0.
REQ-025 TIMEOUT_CYCLES=16, table {0:(84,7)}, only (80,x) stores -> timeout=1 after 16 RUN cycles, match_count=0.
REQ-026 Table {0:(84,7),1:(88,3)}, exp_count=2; store (88,3) first -> fail, fail_addr=88; re-start then (84,7),(88,3) -> pass, match_count=2.
REQ-027 exp_count=0, start -> pass on first RUN cycle; reset=0 mid-RUN after one match -> all outputs 0, state IDLE next cycle.
REQ-028 TIMEOUT_CYCLES=16, final matching store on counter value 15 -> pass=1, timeout=0.
